pipeline_fifo_stage: RTL and testbench

- Buffered pipeline stage: a drop-in neighbour for the single-entry pipeline_stage.
- Placed directly downstream of the last pipeline_stage. It absorbs output while the sink asserts busy, so upstream stages drain instead of stalling immediately.
- Uses the same valid/busy handshake on both sides, so it can be chained before or after any pipeline_stage.
- Storage is a circular buffer of P_DEPTH entries with first-in/first-out ordering.

---
 rtl/pipeline_fifo_stage.sv | 74 +++++++
 tb/tb_pipeline_fifo_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipeline_fifo_stage.sv
// Buffered pipeline stage: a P_DEPTH-entry circular FIFO that uses the same valid/busy
// handshake as pipeline_stage on both sides, so it can be chained with one in either order.
module pipeline_fifo_stage #(
  parameter int P_N       = 1,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iFLUSH,
  input  logic                 iPREV_VALID,
  output logic                 oPREV_BUSY,
  input  logic [P_N-1:0]       iPREV_DATA,
  output logic                 oNEXT_VALID,
  input  logic                 iNEXT_BUSY,
  output logic [P_N-1:0]       oNEXT_DATA,
  output logic [P_DEPTH_N:0]   oCOUNT
);

  localparam logic [P_DEPTH_N-1:0] PTR_ONE  = (P_DEPTH_N)'(1);
  localparam logic [P_DEPTH_N:0]   CNT_ONE  = (P_DEPTH_N+1)'(1);
  localparam logic [P_DEPTH_N:0]   CNT_FULL = (P_DEPTH_N+1)'(P_DEPTH);

  logic [P_N-1:0]       mem [P_DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr;
  logic [P_DEPTH_N-1:0] rd_ptr;
  logic [P_DEPTH_N:0]   count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 clear;

  // Busy comes only from the registered count, so a full FIFO refuses a push even
  // when a pop happens in the same cycle; this keeps chained busy paths registered.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = iPREV_VALID && !full;
  assign pop   = !empty && !iNEXT_BUSY;
  assign clear = iRESET_SYNC || iFLUSH;

  assign oPREV_BUSY  = full;
  assign oNEXT_VALID = !empty;
  assign oNEXT_DATA  = mem[rd_ptr];
  assign oCOUNT      = count;

  always_ff @(posedge iCLOCK) begin
    if (push && !clear) begin
      mem[wr_ptr] <= iPREV_DATA;
    end
  end

  // Count is kept separately from the pointers, so they may wrap freely with no full/empty ambiguity.
  always_ff @(posedge iCLOCK) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_fifo_stage.sv
// Scoreboard bench for pipeline_fifo_stage: directed test-plan sequences followed by
// randomized traffic, checked against a queue model of the FIFO's contents.
module tb_pipeline_fifo_stage;

  localparam int P_N       = 8;
  localparam int P_DEPTH   = 4;
  localparam int P_DEPTH_N = 2;

  logic                iCLOCK = 1'b0;
  logic                iRESET_SYNC;
  logic                iFLUSH;
  logic                iPREV_VALID;
  logic                oPREV_BUSY;
  logic [P_N-1:0]      iPREV_DATA;
  logic                oNEXT_VALID;
  logic                iNEXT_BUSY;
  logic [P_N-1:0]      oNEXT_DATA;
  logic [P_DEPTH_N:0]  oCOUNT;

  int checks = 0;
  int passes = 0;
  int pops_seen = 0;
  bit armed = 1'b0;
  logic [P_N-1:0] exp_q[$];

  pipeline_fifo_stage #(.P_N(P_N), .P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) dut (
    .iCLOCK(iCLOCK),
    .iRESET_SYNC(iRESET_SYNC),
    .iFLUSH(iFLUSH),
    .iPREV_VALID(iPREV_VALID),
    .oPREV_BUSY(oPREV_BUSY),
    .iPREV_DATA(iPREV_DATA),
    .oNEXT_VALID(oNEXT_VALID),
    .iNEXT_BUSY(iNEXT_BUSY),
    .oNEXT_DATA(oNEXT_DATA),
    .oCOUNT(oCOUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs are held across the next rising edge, then released 1 time unit after it.
  task automatic apply_stimulus(input bit valid, input logic [P_N-1:0] data, input bit busy,
                                input bit flush, input bit rst);
    iPREV_VALID = valid;
    iPREV_DATA  = data;
    iNEXT_BUSY  = busy;
    iFLUSH      = flush;
    iRESET_SYNC = rst;
    @(posedge iCLOCK);
    #1;
  endtask

  // Monitor: at the falling edge, compare the DUT against the model, then advance the
  // model by what the upcoming rising edge will do with the inputs now being held.
  always @(negedge iCLOCK) begin
    if (armed) begin
      int sz;
      bit do_push;
      bit do_pop;
      sz = exp_q.size();
      check_output("count", 32'(oCOUNT), 32'(sz));
      check_output("next_valid", 32'(oNEXT_VALID), 32'(sz != 0));
      check_output("prev_busy", 32'(oPREV_BUSY), 32'(sz == P_DEPTH));
      if (sz != 0) begin
        check_output("head_data", 32'(oNEXT_DATA), 32'(exp_q[0]));
      end
      do_push = iPREV_VALID && (sz < P_DEPTH);
      do_pop  = (sz != 0) && !iNEXT_BUSY;
      if (iRESET_SYNC || iFLUSH) begin
        exp_q.delete();
      end else begin
        if (do_pop) begin
          check_output("pop_data", 32'(oNEXT_DATA), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          pops_seen++;
        end
        if (do_push) begin
          exp_q.push_back(iPREV_DATA);
        end
      end
    end
  end

  initial begin
    iRESET_SYNC = 1'b1;
    iFLUSH      = 1'b0;
    iPREV_VALID = 1'b0;
    iPREV_DATA  = '0;
    iNEXT_BUSY  = 1'b0;

    apply_stimulus(0, 8'h00, 0, 0, 1);
    armed = 1'b1;
    apply_stimulus(0, 8'h00, 0, 0, 1);
    repeat (3) apply_stimulus(0, 8'h00, 0, 0, 0);

    // Fill while blocked, then offer a fifth value that must be refused.
    apply_stimulus(1, 8'h11, 1, 0, 0);
    apply_stimulus(1, 8'h22, 1, 0, 0);
    apply_stimulus(1, 8'h33, 1, 0, 0);
    apply_stimulus(1, 8'h44, 1, 0, 0);
    repeat (2) apply_stimulus(1, 8'h55, 1, 0, 0);
    repeat (5) apply_stimulus(0, 8'h00, 0, 0, 0);

    // Streaming through an unblocked FIFO wraps both pointers.
    for (int i = 1; i <= 10; i++) apply_stimulus(1, 8'(i), 0, 0, 0);
    repeat (2) apply_stimulus(0, 8'h00, 0, 0, 0);

    // Full with a simultaneous pop: push refused, then accepted next cycle.
    for (int i = 0; i < 4; i++) apply_stimulus(1, 8'(8'hA0 + i), 1, 0, 0);
    apply_stimulus(1, 8'hB4, 0, 0, 0);
    apply_stimulus(1, 8'hB4, 1, 0, 0);
    apply_stimulus(0, 8'h00, 0, 0, 0);

    // Flush at count 3 with a push and pop pending; then the same using reset.
    apply_stimulus(0, 8'h00, 1, 0, 0);
    apply_stimulus(1, 8'h77, 0, 1, 0);
    apply_stimulus(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 8'(8'hC0 + i), 1, 0, 0);
    apply_stimulus(1, 8'h77, 0, 0, 1);
    apply_stimulus(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 8'(8'hD0 + i), 0, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 199) == 0));
    end
    repeat (P_DEPTH + 2) apply_stimulus(0, 8'h00, 0, 0, 0);

    armed = 1'b0;
    check_output("final_empty", 32'(oNEXT_VALID), 32'd0);
    check_output("pops_nonzero", 32'(pops_seen > 20), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
